// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter and its neighbours.
// Holds the ALU opcode encodings, the arbiter FSM state encoding and the
// default operand/opcode widths. Contains no ports or logic.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OP_W  = 3;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOT_A  = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_PASS_A = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way combinational round-robin arbiter.
// Ports:
//   valid0_i, valid1_i : request valids from requester 0 and 1
//   last_grant_i       : index of the requester served most recently
//   gnt_o              : one-hot grant (bit N = requester N wins)
//   gnt_idx_o          : index of the winner (only meaningful when gnt_o != 0)
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // A lone requester always wins; on contention the requester that was not
  // served last time wins.
  assign gnt_o[0]  = valid0_i & (~valid1_i | last_grant_i);
  assign gnt_o[1]  = valid1_i & (~valid0_i | ~last_grant_i);
  assign gnt_idx_o = gnt_o[1];

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// A granted request's opcode and operands are registered onto alu_*; the ALU
// result is captured one cycle later and presented on the granted requester's
// response channel until that requester accepts it.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) : request channels
//   alu_op, alu_a, alu_b            : registered operation toward the ALU
//   alu_y, alu_cout                 : ALU result and carry/borrow
//   rspN_valid/ready/y/cout (N=0,1) : response channels
//   busy                            : high whenever the FSM is not idle
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp0_cout,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic             rsp1_cout,

  output logic             busy
);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic [OP_W-1:0]  alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] res_y_q;
  logic             res_cout_q;

  logic [1:0]       arb_gnt;
  logic             arb_idx;
  logic             in_idle;
  logic             in_resp;
  logic             rsp_accept;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arb2 u_rr_arb2 (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .gnt_idx_o    (arb_idx)
  );

  assign in_idle = (state_q == IDLE);
  assign in_resp = (state_q == RESP);

  // The arbiter only grants a valid requester, so ready doubles as handshake.
  assign req0_ready = in_idle & arb_gnt[0];
  assign req1_ready = in_idle & arb_gnt[1];

  assign sel_op = arb_idx ? req1_op : req0_op;
  assign sel_a  = arb_idx ? req1_a  : req0_a;
  assign sel_b  = arb_idx ? req1_b  : req0_b;

  assign rsp_accept = grant_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_y_q      <= '0;
      res_cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            alu_op_q <= sel_op;
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            grant_q  <= arb_idx;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          // alu_* have been stable for a full cycle; the ALU output is settled.
          res_y_q    <= alu_y;
          res_cout_q <= alu_cout;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_accept) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

  // Only the granted port sees the result; the other port reads all zeros.
  assign rsp0_valid = in_resp & ~grant_q;
  assign rsp1_valid = in_resp &  grant_q;
  assign rsp0_y     = rsp0_valid ? res_y_q    : '0;
  assign rsp0_cout  = rsp0_valid ? res_cout_q : 1'b0;
  assign rsp1_y     = rsp1_valid ? res_y_q    : '0;
  assign rsp1_cout  = rsp1_valid ? res_cout_q : 1'b0;

  assign busy = ~in_idle;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed testbench for alu_req_arbiter with a behavioural ALU attached.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cout;
  logic       rsp0_valid, rsp0_ready, rsp0_cout;
  logic [7:0] rsp0_y;
  logic       rsp1_valid, rsp1_ready, rsp1_cout;
  logic [7:0] rsp1_y;
  logic       busy;

  int passed = 0;
  int total  = 0;

  alu_req_arbiter #(.WIDTH(8), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_cout(rsp1_cout),
    .busy(busy)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_y    = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      OP_AND:    alu_y = alu_a & alu_b;
      OP_OR:     alu_y = alu_a | alu_b;
      OP_XOR:    alu_y = alu_a ^ alu_b;
      OP_NOT_A:  alu_y = ~alu_a;
      OP_ADD:    {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:    {alu_cout, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      OP_PASS_A: alu_y = alu_a;
      OP_PASS_B: alu_y = alu_b;
      default:   alu_y = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    #3;
    total++; if (req0_ready !== 1'b0) $display("FAIL rst_req0_ready actual=%0h expected=0", req0_ready); else passed++;
    total++; if (rsp0_valid !== 1'b0) $display("FAIL rst_rsp0_valid actual=%0h expected=0", rsp0_valid); else passed++;
    total++; if (rsp1_valid !== 1'b0) $display("FAIL rst_rsp1_valid actual=%0h expected=0", rsp1_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy actual=%0h expected=0", busy); else passed++;
    total++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL rst_alu_regs actual=%0h expected=0", {alu_op, alu_a, alu_b}); else passed++;
    total++; if (rsp0_y !== 8'h00) $display("FAIL rst_rsp0_y actual=%0h expected=0", rsp0_y); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy actual=%0h expected=0", busy); else passed++;
  endtask

  task automatic test_single_or;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_OR; req0_a = 8'hF0; req0_b = 8'h0F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL or_req0_ready actual=%0h expected=1", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL or_req1_ready actual=%0h expected=0", req1_ready); else passed++;
    @(negedge clk); req0_valid = 1'b0; #1;
    total++; if (req0_ready !== 1'b0) $display("FAIL or_ready_pulse actual=%0h expected=0", req0_ready); else passed++;
    total++; if (alu_op !== OP_OR) $display("FAIL or_alu_op actual=%0h expected=1", alu_op); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL or_busy_exec actual=%0h expected=1", busy); else passed++;
    total++; if (rsp0_valid !== 1'b0) $display("FAIL or_rsp0_early actual=%0h expected=0", rsp0_valid); else passed++;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1) $display("FAIL or_rsp0_valid actual=%0h expected=1", rsp0_valid); else passed++;
    total++; if (rsp0_y !== 8'hFF) $display("FAIL or_rsp0_y actual=%0h expected=ff", rsp0_y); else passed++;
    total++; if (rsp0_cout !== 1'b0) $display("FAIL or_rsp0_cout actual=%0h expected=0", rsp0_cout); else passed++;
    total++; if (rsp1_valid !== 1'b0) $display("FAIL or_rsp1_valid actual=%0h expected=0", rsp1_valid); else passed++;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b0) $display("FAIL or_rsp0_drop actual=%0h expected=0", rsp0_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL or_busy_idle actual=%0h expected=0", busy); else passed++;
    total++; if (alu_op !== OP_OR) $display("FAIL or_alu_hold actual=%0h expected=1", alu_op); else passed++;
  endtask

  task automatic test_both_valid;
    @(negedge clk); rst_n = 1'b0; #2; rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hAA; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 8'hAA; req1_b = 8'hFF;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL both_req0_first actual=%0h expected=1", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL both_req1_wait actual=%0h expected=0", req1_ready); else passed++;
    @(negedge clk); req0_valid = 1'b0; #1;
    total++; if (busy !== 1'b1) $display("FAIL both_busy_exec0 actual=%0h expected=1", busy); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL both_req1_exec actual=%0h expected=0", req1_ready); else passed++;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1) $display("FAIL both_rsp0_valid actual=%0h expected=1", rsp0_valid); else passed++;
    total++; if (rsp0_y !== 8'h0A) $display("FAIL both_rsp0_y actual=%0h expected=0a", rsp0_y); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL both_busy_resp0 actual=%0h expected=1", busy); else passed++;
    @(negedge clk);
    total++; if (req1_ready !== 1'b1) $display("FAIL both_req1_ready actual=%0h expected=1", req1_ready); else passed++;
    @(negedge clk); req1_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL both_busy_exec1 actual=%0h expected=1", busy); else passed++;
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b1) $display("FAIL both_rsp1_valid actual=%0h expected=1", rsp1_valid); else passed++;
    total++; if (rsp1_y !== 8'h55) $display("FAIL both_rsp1_y actual=%0h expected=55", rsp1_y); else passed++;
    total++; if (rsp0_y !== 8'h00) $display("FAIL both_rsp0_y_idle actual=%0h expected=0", rsp0_y); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL both_idle actual=%0h expected=0", busy); else passed++;
  endtask

  task automatic test_alternate;
    logic e_r0, e_r1, e_v0, e_v1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 8'h05; req1_b = 8'h07;
    for (int i = 0; i < 18; i++) begin
      #1;
      e_r0 = (i % 3 == 0) && ((i / 3) % 2 == 0);
      e_r1 = (i % 3 == 0) && ((i / 3) % 2 == 1);
      e_v0 = (i % 3 == 2) && ((i / 3) % 2 == 0);
      e_v1 = (i % 3 == 2) && ((i / 3) % 2 == 1);
      total++; if (req0_ready !== e_r0) $display("FAIL alt_req0_ready cyc=%0d actual=%0h expected=%0h", i, req0_ready, e_r0); else passed++;
      total++; if (req1_ready !== e_r1) $display("FAIL alt_req1_ready cyc=%0d actual=%0h expected=%0h", i, req1_ready, e_r1); else passed++;
      total++; if (rsp0_valid !== e_v0) $display("FAIL alt_rsp0_valid cyc=%0d actual=%0h expected=%0h", i, rsp0_valid, e_v0); else passed++;
      total++; if (rsp1_valid !== e_v1) $display("FAIL alt_rsp1_valid cyc=%0d actual=%0h expected=%0h", i, rsp1_valid, e_v1); else passed++;
      if (e_v0) begin
        total++; if ({rsp0_cout, rsp0_y} !== 9'h003) $display("FAIL alt_rsp0_res cyc=%0d actual=%0h expected=003", i, {rsp0_cout, rsp0_y}); else passed++;
      end
      if (e_v1) begin
        total++; if ({rsp1_cout, rsp1_y} !== 9'h1FE) $display("FAIL alt_rsp1_res cyc=%0d actual=%0h expected=1fe", i, {rsp1_cout, rsp1_y}); else passed++;
      end
      if (i == 17) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) $display("FAIL alt_idle actual=%0h expected=0", busy); else passed++;
  endtask

  task automatic test_stall;
    @(negedge clk);
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 8'hFF; req1_b = 8'h01;
    rsp1_ready = 1'b0; req0_valid = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b1) $display("FAIL stall_req1_ready actual=%0h expected=1", req1_ready); else passed++;
    @(negedge clk); req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'h3C; req0_b = 8'h0F;
    #1;
    total++; if (req0_ready !== 1'b0) $display("FAIL stall_req0_exec actual=%0h expected=0", req0_ready); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++; if (rsp1_valid !== 1'b1) $display("FAIL stall_rsp1_valid k=%0d actual=%0h expected=1", k, rsp1_valid); else passed++;
      total++; if ({rsp1_cout, rsp1_y} !== 9'h100) $display("FAIL stall_rsp1_res k=%0d actual=%0h expected=100", k, {rsp1_cout, rsp1_y}); else passed++;
      total++; if (req0_ready !== 1'b0) $display("FAIL stall_req0_ready k=%0d actual=%0h expected=0", k, req0_ready); else passed++;
      if (k == 4) rsp1_ready = 1'b1;
    end
    @(negedge clk); #1;
    total++; if (rsp1_valid !== 1'b0) $display("FAIL stall_rsp1_drop actual=%0h expected=0", rsp1_valid); else passed++;
    total++; if (req0_ready !== 1'b1) $display("FAIL stall_req0_after actual=%0h expected=1", req0_ready); else passed++;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    total++; if (rsp0_y !== 8'h0C) $display("FAIL stall_rsp0_y actual=%0h expected=0c", rsp0_y); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL stall_idle actual=%0h expected=0", busy); else passed++;
  endtask

  task automatic test_reset_exec;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 8'h10; req0_b = 8'h20; req1_valid = 1'b0;
    @(negedge clk); req0_valid = 1'b0; #1;
    total++; if (alu_op !== OP_SUB) $display("FAIL rexec_alu_op actual=%0h expected=5", alu_op); else passed++;
    #1; rst_n = 1'b0; #1;
    total++; if (busy !== 1'b0) $display("FAIL rexec_busy actual=%0h expected=0", busy); else passed++;
    total++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL rexec_alu_regs actual=%0h expected=0", {alu_op, alu_a, alu_b}); else passed++;
    #1; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rexec_no_rsp k=%0d actual=%0h%0h expected=00", k, rsp0_valid, busy); else passed++;
    end
    req0_valid = 1'b1; req0_op = OP_PASS_A; req0_a = 8'h77; req0_b = 8'h00;
    req1_valid = 1'b1; req1_op = OP_AND;    req1_a = 8'h11; req1_b = 8'h11;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL rexec_req0_prio actual=%0h expected=1", req0_ready); else passed++;
    total++; if (req1_ready !== 1'b0) $display("FAIL rexec_req1_wait actual=%0h expected=0", req1_ready); else passed++;
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp0_y !== 8'h77) $display("FAIL rexec_rsp0 actual=%0h/%0h expected=1/77", rsp0_valid, rsp0_y); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rexec_idle actual=%0h expected=0", busy); else passed++;
  endtask

  task automatic test_pass_b;
    @(negedge clk);
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_PASS_B; req0_a = 8'h11; req0_b = 8'h3C;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL passb_ready actual=%0h expected=1", req0_ready); else passed++;
    @(negedge clk); req0_valid = 1'b0;
    total++; if (rsp0_valid !== 1'b0) $display("FAIL passb_early actual=%0h expected=0", rsp0_valid); else passed++;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1) $display("FAIL passb_valid actual=%0h expected=1", rsp0_valid); else passed++;
    total++; if ({rsp0_cout, rsp0_y} !== 9'h03C) $display("FAIL passb_res actual=%0h expected=03c", {rsp0_cout, rsp0_y}); else passed++;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b0) $display("FAIL passb_single actual=%0h expected=0", rsp0_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL passb_idle actual=%0h expected=0", busy); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    test_reset;
    test_single_or;
    test_both_valid;
    test_alternate;
    test_stall;
    test_reset_exec;
    test_pass_b;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
